imem_boot_ctrl: RTL and testbench

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

---
 rtl/imem_boot_pkg.sv | 19 +
 rtl/rx_word_packer.sv | 43 ++++
 rtl/imem_boot_ctrl.sv | 139 +++++++++++++
 tb/tb_imem_boot_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Defining IMEM_BOOT_CHECKSUM_EN adds the trailing XOR-checksum state.
package imem_boot_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
`ifdef IMEM_BOOT_CHECKSUM_EN
    , ST_CSUM = 3'd7
`endif
  } state_t;
endpackage

// File: rtl/rx_word_packer.sv
// Assembles little-endian bytes into a 32-bit word; byte k lands in bits [8k+7:8k].
// word_full flags the handshake that delivers the last byte of a word.
module rx_word_packer
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);
  localparam int IW = $clog2(BYTES_PER_WORD);

  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d  = '0;
      word_d = '0;
    end else if (load) begin
      word_d[8*idx_q +: 8] = byte_in;
      idx_d = idx_q + 1'b1;  // wraps to 0 after the last byte of a word
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word      = word_q;
  assign word_full = load && !clear && (idx_q == IW'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader: receives a length-prefixed byte stream, writes words into IMEM,
// and holds the core in reset until a load completes. Option: IMEM_BOOT_CHECKSUM_EN.
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          imem_we,
  output logic [31:0]   imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rst,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] word_count
);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t        state_q, state_d;
  state_t        fin_st;
  logic [15:0]   len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0]   n_rx;
  logic [31:0]   word;
  logic          pk_load, pk_clear, word_full;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  assign fin_st = ST_CSUM;
`else
  assign fin_st = ST_DONE;
`endif

  assign n_rx    = {rx_data, len_q[7:0]};
  assign cnt_inc = cnt_q + 1'b1;
  assign pk_load = rx_valid && rx_ready && (state_q == ST_DATA);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    pk_clear = 1'b0;
    rx_ready = 1'b0;
    imem_we  = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d  = ST_LEN0;
          cnt_d    = '0;
          pk_clear = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
          csum_d   = '0;
`endif
        end
      end
      ST_LEN0: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          len_d = n_rx;
          if ({1'b0, n_rx} > DEPTH_L) state_d = ST_ERR;
          else if (n_rx == '0)        state_d = fin_st;
          else                        state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        rx_ready = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (rx_valid) csum_d = csum_q ^ rx_data;
`endif
        if (word_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        imem_we = 1'b1;
        cnt_d   = cnt_inc;
        state_d = (32'(cnt_inc) == 32'(len_q)) ? fin_st : ST_DATA;
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      ST_CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef IMEM_BOOT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  rx_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .load      (pk_load),
    .clear     (pk_clear),
    .byte_in   (rx_data),
    .word      (word),
    .word_full (word_full)
  );

  // Address/data are forced to zero outside the write strobe.
  assign imem_waddr = imem_we ? 32'({cnt_q, 2'b00}) : '0;
  assign imem_wdata = imem_we ? word : '0;
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign cpu_rst    = (state_q != ST_DONE);
  assign word_count = cnt_q;
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized self-checking bench for imem_boot_ctrl against a stream-level model.
module tb_imem_boot_ctrl;
  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, start, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, imem_we, cpu_rst, done, err;
  logic [31:0]   imem_waddr, imem_wdata;
  logic [CW-1:0] word_count;

  int checks   = 0;
  int failures = 0;
  logic [63:0] wr_q[$];

  imem_boot_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we) wr_q.push_back({imem_waddr, imem_wdata});

  // Called and returns at a negedge; random idle gaps may carry ignored start pulses.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      start    = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!rx_ready) begin
      checks++; failures++;
      $display("FAIL handshake_timeout byte=%02h rx_ready=%0b required=1", b, rx_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++; if (rx_ready !== 1'b0)    begin failures++; $display("FAIL %s_rx_ready got=%0b exp=0", tag, rx_ready); end
    checks++; if (imem_we !== 1'b0)     begin failures++; $display("FAIL %s_imem_we got=%0b exp=0", tag, imem_we); end
    checks++; if (imem_waddr !== 32'h0) begin failures++; $display("FAIL %s_waddr got=%h exp=0", tag, imem_waddr); end
    checks++; if (imem_wdata !== 32'h0) begin failures++; $display("FAIL %s_wdata got=%h exp=0", tag, imem_wdata); end
    checks++; if (cpu_rst !== 1'b1)     begin failures++; $display("FAIL %s_cpu_rst got=%0b exp=1", tag, cpu_rst); end
    checks++; if (done !== 1'b0)        begin failures++; $display("FAIL %s_done got=%0b exp=0", tag, done); end
    checks++; if (err !== 1'b0)         begin failures++; $display("FAIL %s_err got=%0b exp=0", tag, err); end
    checks++; if (word_count !== '0)    begin failures++; $display("FAIL %s_word_count got=%0d exp=0", tag, word_count); end
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] d[$]);
    logic [7:0] x = 8'h0;
    foreach (d[i]) x ^= d[i];
    return x;
  endfunction

  // Full session: start, length, data (if N fits), checksum byte (if built in), then check outcome.
  task automatic run_session(input int n, input logic [7:0] d[$], input logic [7:0] cs,
                             input bit gaps, input string tag);
    logic [15:0] nl = 16'(n);
    logic [63:0] exp_w[$];
    bit          exp_err;
    int          g = 0;
    exp_err = (n > DEPTH);
    if (!exp_err)
      for (int i = 0; i < n; i++)
        exp_w.push_back({32'(4 * i), d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]});
`ifdef IMEM_BOOT_CHECKSUM_EN
    if (!exp_err && cs != xor_of(d)) exp_err = 1'b1;
`endif
    wr_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(nl[7:0], gaps);
    send_byte(nl[15:8], gaps);
    if (n <= DEPTH) begin
      foreach (d[i]) send_byte(d[i], gaps);
`ifdef IMEM_BOOT_CHECKSUM_EN
      send_byte(cs, gaps);
`endif
    end
    rx_valid = 1'b0;
    while (!(done || err) && g < 10) begin @(negedge clk); g++; end
    checks++; if (done !== !exp_err) begin failures++; $display("FAIL %s_done got=%0b exp=%0b", tag, done, !exp_err); end
    checks++; if (err !== exp_err)   begin failures++; $display("FAIL %s_err got=%0b exp=%0b", tag, err, exp_err); end
    checks++; if (cpu_rst !== exp_err) begin failures++; $display("FAIL %s_cpu_rst got=%0b exp=%0b", tag, cpu_rst, exp_err); end
    checks++;
    if (32'(word_count) !== ((n <= DEPTH) ? n : 0)) begin
      failures++; $display("FAIL %s_word_count got=%0d exp=%0d", tag, word_count, (n <= DEPTH) ? n : 0);
    end
    checks++;
    if (wr_q.size() != exp_w.size()) begin
      failures++; $display("FAIL %s_write_count got=%0d exp=%0d", tag, wr_q.size(), exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        checks++;
        if (wr_q[i] !== exp_w[i]) begin
          failures++;
          $display("FAIL %s_write%0d got=%h@%h exp=%h@%h", tag, i, wr_q[i][31:0], wr_q[i][63:32],
                   exp_w[i][31:0], exp_w[i][63:32]);
        end
      end
    end
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] d[$]);
    d.delete();
    for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'h5A;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vector();
    logic [7:0] d[$] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h02, 8'hA0, 8'h00};
    run_session(2, d, xor_of(d), 1'b0, "vector");
    checks++; if (wr_q.size() < 2 || wr_q[0] !== {32'h0, 32'h00500013} || wr_q[1] !== {32'h4, 32'h00A00293}) begin
      failures++; $display("FAIL vector_literal got_size=%0d exp=2 words 00500013@0 00a00293@4", wr_q.size());
    end
  endtask

  task automatic test_random_valid();
    logic [7:0] d[$];
    rand_bytes(3, d);
    run_session(3, d, xor_of(d), 1'b1, "rvalid");
  endtask

  task automatic test_random_loads();
    logic [7:0] d[$];
    for (int k = 0; k < 6; k++) begin
      int n = $urandom_range(1, 10);
      rand_bytes(n, d);
      run_session(n, d, xor_of(d), 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end
  endtask

  task automatic test_full_depth();
    logic [7:0] d[$];
    rand_bytes(DEPTH, d);
    run_session(DEPTH, d, xor_of(d), 1'b0, "full");
  endtask

  task automatic test_overflow();
    logic [7:0] d[$];
    d.delete();
    run_session(DEPTH + 1, d, 8'h00, 1'b0, "ovf");
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL ovf_rx_ready got=%0b exp=0", rx_ready); end
  endtask

  task automatic test_zero();
    wr_q.delete();
    start = 1'b1; @(negedge clk); start = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    rx_valid = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
    checks++; if (done !== 1'b0 || rx_ready !== 1'b1) begin failures++; $display("FAIL zero_csum_wait done=%0b rx_ready=%0b exp=0/1", done, rx_ready); end
    send_byte(8'h00, 1'b0);
    rx_valid = 1'b0;
`endif
    checks++; if (done !== 1'b1)    begin failures++; $display("FAIL zero_done got=%0b exp=1", done); end
    checks++; if (cpu_rst !== 1'b0) begin failures++; $display("FAIL zero_cpu_rst got=%0b exp=0", cpu_rst); end
    checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL zero_writes got=%0d exp=0", wr_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d[$];
    start = 1'b1; @(negedge clk); start = 1'b0;
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    reset = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'hCC;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    rand_bytes(2, d);
    run_session(2, d, xor_of(d), 1'b0, "postrst");
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[$];
    rand_bytes(1, d);
    run_session(1, d, xor_of(d), 1'b0, "b2b_a");
    start = 1'b1; @(negedge clk); start = 1'b0;
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL b2b_done_clr got=%0b exp=0", done); end
    checks++; if (cpu_rst !== 1'b1)   begin failures++; $display("FAIL b2b_cpu_rst got=%0b exp=1", cpu_rst); end
    checks++; if (word_count !== '0)  begin failures++; $display("FAIL b2b_wc_clr got=%0d exp=0", word_count); end
    checks++; if (rx_ready !== 1'b1)  begin failures++; $display("FAIL b2b_len0_ready got=%0b exp=1", rx_ready); end
    rand_bytes(2, d);
    run_session(2, d, xor_of(d), 1'b1, "b2b_b");
  endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] d[$] = '{8'h13, 8'h00, 8'h00, 8'h00};
    run_session(1, d, 8'h12, 1'b0, "csum_bad");
    run_session(1, d, 8'h13, 1'b0, "csum_good");
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    test_reset();
    test_vector();
    test_random_valid();
    test_random_loads();
    test_full_depth();
    test_overflow();
    test_zero();
    test_reset_mid();
    test_back_to_back();
`ifdef IMEM_BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
